seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 4-digit common-anode 7-segment display: takes four
//  BCD nibbles plus decimal points from the counter/position logic and scans one digit at
//  a time onto seg/dig. Sits directly downstream of the button-driven counter stage and
//  directly drives the board pins. New values apply only at frame boundaries (no tearing).
//  Digit on-windows are separated by a blanking gap to suppress ghosting.
// PARAMETERS
//  SCAN_CYCLES   32'd12500  clk cycles each digit is lit (SHOW window), must be >= 1
//  BLANK_CYCLES  32'd250    clk cycles all digits off between digits, must be >= 1
// PORTS
//  clk          in   1   system clock; single clock domain
//  rstn         in   1   reset, synchronous, active-low
//  digits_i     in   16  [3:0]=digit0 (leftmost) .. [15:12]=digit3 (rightmost), BCD
//  dp_i         in   4   decimal point per digit, 1 = lit; bit n = digit n
//  lz_en_i      in   1   1 = leading-zero suppression enabled
//  load_i       in   1   1-cycle strobe: capture digits_i/dp_i/lz_en_i into pending regs
//  pending_o    out  1   1 = captured value not yet shown
//  frame_done_o out  1   1-cycle pulse at each frame boundary
//  seg          out  8   segments, active-low, [7]=dp, [6:0]=g..a
//  dig          out  4   digit select, active-low; digit0=4'b1110 .. digit3=4'b0111
// BEHAVIOUR
//  - All state and outputs are flops; seg/dig are loaded from next-state logic so they
//    change on the same edge as state/idx. No combinational path from inputs to outputs.
//  - Reset (rstn==0 at posedge): state=BLANK, idx=3, cnt=0, seg=8'hFF, dig=4'hF,
//    frame_done_o=0, pending_o=0, shown digits=16'h0000, shown dp=0, shown lz_en=0.
//  - FSM {SHOW, BLANK}, cnt counts 0..N-1 in each state:
//    SHOW : dig = one-hot-low(idx), seg = glyph(idx); after SCAN_CYCLES cycles -> BLANK.
//    BLANK: dig=4'hF, seg=8'hFF; after BLANK_CYCLES cycles -> SHOW, idx=(idx+1) mod 4.
//  - Frame boundary = BLANK->SHOW edge with idx 3->0. frame_done_o=1 for exactly that one
//    cycle; the pending value (if pending_o) is copied into the shown regs and pending_o
//    clears on that edge, so digit0 of the new frame already uses the new data.
//  - First boundary occurs BLANK_CYCLES cycles after reset release; frame length =
//    4*(SCAN_CYCLES+BLANK_CYCLES) cycles.
//  - load_i: pending regs <= inputs, pending_o <= 1. Load while pending: latest wins.
//    Load in the boundary cycle: inputs bypass pending and go straight to the shown regs.
//    pending_o stays 0.
//  - Glyphs (dp bit forced 0 when shown dp bit set):
//    0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=D8 8=80 9=90; 10..14 = 8'h89 (error "H");
//    15 = 8'hFF (blank, dp may still light).
//  - Leading-zero suppression (shown lz_en=1): digit n in 0..2 is blanked (8'hFF, dp still
//    honoured) if it and every digit left of it are 0. Digit3 is never suppressed.
//  - rstn low mid-frame: next edge returns to the reset state; any pending load is lost.
//  - rstn has priority over load_i in the same cycle.
// TESTING (SCAN_CYCLES=4, BLANK_CYCLES=2 -> frame = 24 cycles)
//  1 Reset, release, no load -> dig=F/seg=FF for 2 cycles; frame_done pulse; then dig=E,
//    seg=C0 for 4 cycles; dig=F for 2; dig=D, seg=C0 ... (shows "0000").
//  2 load digits=16'h4321, dp=4'b0010 mid-frame -> pending_o=1 until next boundary; next
//    frame: 1110/F9, 1101/24 (A4 w/ dp), 1011/B0, 0111/99.
//  3 lz_en=1, digits=16'h7000 -> digits0..2 seg=FF while dig active; digit3 seg=D8;
//    digits=16'h0000 -> only digit3 shows C0.
//  4 digits nibble 4'hA and 4'hF -> that digit shows 89 and FF respectively.
//  5 Two loads before a boundary (1111 then 2222) -> frame shows 2222; load in boundary
//    cycle -> applied immediately, pending_o never rises.
//  6 rstn low for 1 cycle during SHOW of digit2 with load pending -> next edge seg=FF,
//    dig=F, pending_o=0; display returns to 0000 with first boundary 2 cycles after release.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   One digit is lit at a time (SHOW window), separated by an all-off BLANK
//   gap to suppress ghosting. New values are captured into pending registers
//   and only become visible at the frame boundary (BLANK->SHOW with idx 3->0),
//   so a frame never mixes old and new data.
//   All outputs are registered and loaded from next-state logic, so seg/dig
//   change on the same edge as the scan state and index.
// ----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter logic [31:0] SCAN_CYCLES  = 32'd12500,  // cycles each digit is lit, >= 1
    parameter logic [31:0] BLANK_CYCLES = 32'd250     // cycles all digits off between digits, >= 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_en_i,
    input  logic        load_i,
    output logic        pending_o,
    output logic        frame_done_o,
    output logic [7:0]  seg,
    output logic [3:0]  dig
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    // One complete display value: four BCD nibbles, decimal points and the
    // leading-zero-suppression enable travel together.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz_en;
    } disp_t;

    // ------------------------------------------------------------------------
    // Glyph helpers
    // ------------------------------------------------------------------------

    // Active-low segment pattern for one nibble, dp bit off.
    function automatic logic [7:0] glyph_of(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hD8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            4'd15:   g = 8'hFF;  // explicit blank code
            default: g = 8'h89;  // 10..14 are not BCD: show "H" as an error marker
        endcase
        return g;
    endfunction

    // Full segment pattern for digit n of a display value, including
    // leading-zero suppression and the decimal point.
    function automatic logic [7:0] digit_seg(input disp_t d, input logic [1:0] n);
        logic [3:0] nib;
        logic       zero_prefix;
        logic [7:0] s;
        case (n)
            2'd0: begin
                nib         = d.digits[3:0];
                zero_prefix = (d.digits[3:0] == 4'h0);
            end
            2'd1: begin
                nib         = d.digits[7:4];
                zero_prefix = (d.digits[7:0] == 8'h00);
            end
            2'd2: begin
                nib         = d.digits[11:8];
                zero_prefix = (d.digits[11:0] == 12'h000);
            end
            default: begin
                // Rightmost digit is never suppressed so "0" still shows.
                nib         = d.digits[15:12];
                zero_prefix = 1'b0;
            end
        endcase
        if (d.lz_en && zero_prefix) begin
            s = 8'hFF;
        end else begin
            s = glyph_of(nib);
        end
        // Decimal point is honoured even on suppressed or blank digits.
        if (d.dp[n]) begin
            s[7] = 1'b0;
        end
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        boundary;

    disp_t       shown_q, shown_d;
    disp_t       pend_q, pend_d;
    logic        pending_q, pending_d;
    disp_t       in_val;

    logic [7:0]  seg_q, seg_d;
    logic [3:0]  dig_q, dig_d;
    logic        frame_done_q, frame_done_d;

    assign in_val = '{digits: digits_i, dp: dp_i, lz_en: lz_en_i};

    // ------------------------------------------------------------------------
    // Scan FSM next state: alternate SHOW/BLANK windows, advance digit index
    // on each BLANK->SHOW edge and flag the frame boundary (idx 3->0).
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (cnt_q == SCAN_CYCLES - 32'd1) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_CYCLES - 32'd1) begin
                    state_d  = ST_SHOW;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Display data next state: loads park in the pending registers and are
    // promoted at the boundary; a load in the boundary cycle itself goes
    // straight to the shown registers and wins over any older pending value.
    // ------------------------------------------------------------------------
    always_comb begin
        shown_d   = shown_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (boundary) begin
            if (load_i) begin
                shown_d = in_val;
            end else if (pending_q) begin
                shown_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (load_i) begin
            pend_d    = in_val;
            pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output next state: computed from the next scan state and next shown
    // value so digit0 of a new frame already carries the new data.
    // ------------------------------------------------------------------------
    always_comb begin
        seg_d        = 8'hFF;
        dig_d        = 4'hF;
        frame_done_d = boundary;
        if (state_d == ST_SHOW) begin
            dig_d = ~(4'b0001 << idx_d);
            seg_d = digit_seg(shown_d, idx_d);
        end
    end

    // ------------------------------------------------------------------------
    // Control and output registers with synchronous active-low reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd3;
            shown_q      <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'hFF;
            dig_q        <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Pending data register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: no reset on the pending payload; it is only ever consumed
        // while pending_q is set, and pending_q itself is reset.
        pend_q <= pend_d;
    end

    assign seg          = seg_q;
    assign dig          = dig_q;
    assign frame_done_o = frame_done_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//   Self-checking bench for seven_seg_scan_driver with SCAN_CYCLES=4 and
//   BLANK_CYCLES=2 (6-cycle digit slot, 24-cycle frame). The reference model
//   is a timeline: it counts edges since reset release and derives the
//   expected digit, window and frame boundary by plain arithmetic, and keeps
//   the shown/pending display values as simple variables.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int SCAN  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SCAN + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic        lz_en_i;
    logic        load_i;
    logic        pending_o;
    logic        frame_done_o;
    logic [7:0]  seg;
    logic [3:0]  dig;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .SCAN_CYCLES (32'd4),
        .BLANK_CYCLES(32'd2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .digits_i    (digits_i),
        .dp_i        (dp_i),
        .lz_en_i     (lz_en_i),
        .load_i      (load_i),
        .pending_o   (pending_o),
        .frame_done_o(frame_done_o),
        .seg         (seg),
        .dig         (dig)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          e;                       // edges with rstn high since last reset edge
    logic [15:0] m_digits, p_digits;
    logic [3:0]  m_dp, p_dp;
    logic        m_lz, p_lz, m_pending;
    logic [13:0] exp_vec;                 // {frame_done, pending, dig, seg}
    logic [13:0] act_vec;

    assign act_vec = {frame_done_o, pending_o, dig, seg};

    function automatic logic [7:0] ref_glyph(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hD8;
            8: return 8'h80;
            9: return 8'h90;
            15: return 8'hFF;
            default: return 8'h89;
        endcase
    endfunction

    // Expected pattern for digit n of the model's shown value.
    function automatic logic [7:0] ref_seg(input int n);
        int         val;
        int         nib;
        bit         all_zero_left;
        logic [7:0] s;
        val           = int'(m_digits);
        nib           = (val >> (4 * n)) % 16;
        all_zero_left = (val % (1 << (4 * (n + 1)))) == 0;
        if (m_lz && n < 3 && all_zero_left) s = 8'hFF;
        else                                s = ref_glyph(nib);
        if (m_dp[n]) s[7] = 1'b0;
        return s;
    endfunction

    function automatic bit is_boundary(input int k);
        return (k >= 2) && ((k - 2) % FRAME == 0);
    endfunction

    function automatic int cur_phase();
        return (e >= 2) ? (e - 2) % FRAME : -1;
    endfunction

    function automatic int next_phase();
        return (e + 1 >= 2) ? (e - 1) % FRAME : -1;
    endfunction

    // Advance one clock: update the model with the inputs present at the
    // edge, then settle and compute the expected outputs.
    task automatic tick();
        int   p;
        int   d;
        logic [3:0] xd;
        @(posedge clk);
        if (!rstn) begin
            e = 0;
            m_digits = '0; m_dp = '0; m_lz = 1'b0; m_pending = 1'b0;
        end else begin
            e++;
            if (is_boundary(e)) begin
                if (load_i) begin
                    m_digits = digits_i; m_dp = dp_i; m_lz = lz_en_i;
                end else if (m_pending) begin
                    m_digits = p_digits; m_dp = p_dp; m_lz = p_lz;
                end
                m_pending = 1'b0;
            end else if (load_i) begin
                p_digits = digits_i; p_dp = dp_i; p_lz = lz_en_i;
                m_pending = 1'b1;
            end
        end
        if (!rstn || e < 2) begin
            exp_vec = {1'b0, m_pending, 4'hF, 8'hFF};
        end else begin
            p  = (e - 2) % FRAME;
            d  = p / SLOT;
            xd = 4'hF;
            if ((p % SLOT) < SCAN) begin
                xd[d] = 1'b0;
                exp_vec = {p == 0, m_pending, xd, ref_seg(d)};
            end else begin
                exp_vec = {1'b0, m_pending, xd, 8'hFF};
            end
        end
        #1;
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
        digits_i = d; dp_i = p; lz_en_i = lz; load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; load_i = 1'b0; digits_i = '0; dp_i = '0; lz_en_i = 1'b0;
        tick();
        tick();
        total++;
        if (act_vec !== {1'b0, 1'b0, 4'hF, 8'hFF}) begin
            bad++; $display("FAIL reset_state act=%h exp=%h", act_vec, {1'b0, 1'b0, 4'hF, 8'hFF});
        end
    endtask

    task automatic test_blank_frame();
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL blank_frame e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
            if (e == 1 || e == 2 || e == 8) begin
                total++;
                if ((e == 1 && act_vec !== {2'b00, 4'hF, 8'hFF}) ||
                    (e == 2 && act_vec !== {2'b10, 4'hE, 8'hC0}) ||
                    (e == 8 && act_vec !== {2'b00, 4'hD, 8'hC0})) begin
                    bad++; $display("FAIL first_boundary e=%0d act=%h", e, act_vec);
                end
            end
        end
    endtask

    task automatic test_load_pending();
        for (int k = 0; k < 30 && next_phase() != 8; k++) begin
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL load_wait e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
        drive_load(16'h4321, 4'b0010, 1'b0);
        total++;
        if (pending_o !== 1'b1 || act_vec !== exp_vec) begin
            bad++; $display("FAIL load_pending pending=%b act=%h exp=%h", pending_o, act_vec, exp_vec);
        end
        for (int k = 0; k < 30 && !is_boundary(e); k++) begin
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL load_run e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            if (cur_phase() % SLOT == 0) begin
                total++;
                if ((cur_phase() == 0  && act_vec !== {2'b10, 4'hE, 8'hF9}) ||
                    (cur_phase() == 6  && act_vec !== {2'b00, 4'hD, 8'h24}) ||
                    (cur_phase() == 12 && act_vec !== {2'b00, 4'hB, 8'hB0}) ||
                    (cur_phase() == 18 && act_vec !== {2'b00, 4'h7, 8'h99})) begin
                    bad++; $display("FAIL frame_4321 ph=%0d act=%h", cur_phase(), act_vec);
                end
            end
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL frame_4321_model e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
    endtask

    // Load a value mid-frame, run into the next frame and check selected
    // digits against fixed expectations as well as against the model.
    task automatic run_frame_with(input logic [15:0] d, input logic [3:0] p, input logic lz,
                                  input logic [7:0] s0, input logic [7:0] s1,
                                  input logic [7:0] s2, input logic [7:0] s3, input string tag);
        for (int k = 0; k < 30 && next_phase() != 3; k++) tick();
        drive_load(d, p, lz);
        for (int k = 0; k < 30 && !is_boundary(e); k++) tick();
        for (int k = 0; k < FRAME; k++) begin
            if (cur_phase() % SLOT == 1) begin
                total++;
                if ((cur_phase() == 1  && act_vec !== {2'b00, 4'hE, s0}) ||
                    (cur_phase() == 7  && act_vec !== {2'b00, 4'hD, s1}) ||
                    (cur_phase() == 13 && act_vec !== {2'b00, 4'hB, s2}) ||
                    (cur_phase() == 19 && act_vec !== {2'b00, 4'h7, s3})) begin
                    bad++; $display("FAIL %s ph=%0d act=%h", tag, cur_phase(), act_vec);
                end
            end
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL %s_model e=%0d act=%h exp=%h", tag, e, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_lz();
        run_frame_with(16'h7000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hD8, "lz_7000");
        run_frame_with(16'h0000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hC0, "lz_0000");
        run_frame_with(16'h0300, 4'b0001, 1'b1, 8'h7F, 8'hFF, 8'hB0, 8'hC0, "lz_dp");
    endtask

    task automatic test_error_glyphs();
        run_frame_with(16'hF2A0, 4'b1000, 1'b0, 8'hC0, 8'h89, 8'hA4, 8'h7F, "err_glyph");
        run_frame_with(16'hEBCF, 4'b0000, 1'b0, 8'hFF, 8'h89, 8'h89, 8'h89, "err_glyph2");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 30 && next_phase() != 2; k++) tick();
        drive_load(16'h1111, 4'b0000, 1'b0);
        drive_load(16'h2222, 4'b0000, 1'b0);
        total++;
        if (pending_o !== 1'b1) begin
            bad++; $display("FAIL b2b_pending act=%b exp=1", pending_o);
        end
        for (int k = 0; k < 30 && !is_boundary(e); k++) begin
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL b2b_run e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
        total++;
        if (act_vec !== {2'b10, 4'hE, 8'hA4}) begin
            bad++; $display("FAIL b2b_latest act=%h exp=%h", act_vec, {2'b10, 4'hE, 8'hA4});
        end
        for (int k = 0; k < 30 && next_phase() != 0; k++) tick();
        drive_load(16'h5678, 4'b0000, 1'b0);
        total++;
        if (act_vec !== {2'b10, 4'hE, 8'h80}) begin
            bad++; $display("FAIL boundary_bypass act=%h exp=%h", act_vec, {2'b10, 4'hE, 8'h80});
        end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            total++;
            if (pending_o !== 1'b0 || act_vec !== exp_vec) begin
                bad++; $display("FAIL bypass_frame e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 30 && next_phase() != 13; k++) tick();
        drive_load(16'h9999, 4'b1111, 1'b0);
        total++;
        if (act_vec !== {2'b01, 4'hB, 8'hC0} && act_vec !== exp_vec) begin
            bad++; $display("FAIL pre_reset act=%h exp=%h", act_vec, exp_vec);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++;
        if (act_vec !== {2'b00, 4'hF, 8'hFF}) begin
            bad++; $display("FAIL midframe_reset act=%h exp=%h", act_vec, {2'b00, 4'hF, 8'hFF});
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL after_reset e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
            if (e == 2) begin
                total++;
                if (act_vec !== {2'b10, 4'hE, 8'hC0}) begin
                    bad++; $display("FAIL reset_boundary act=%h exp=%h", act_vec, {2'b10, 4'hE, 8'hC0});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            digits_i = 16'($urandom);
            dp_i     = 4'($urandom);
            lz_en_i  = 1'($urandom);
            load_i   = ($urandom_range(0, 9) == 0);
            rstn     = !($urandom_range(0, 199) == 0);
            tick();
            total++;
            if (act_vec !== exp_vec) begin
                bad++; $display("FAIL random e=%0d act=%h exp=%h", e, act_vec, exp_vec);
            end
        end
        rstn   = 1'b1;
        load_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        e = 0;
        m_digits = '0; m_dp = '0; m_lz = 1'b0; m_pending = 1'b0;
        p_digits = '0; p_dp = '0; p_lz = 1'b0;
        test_reset();
        test_blank_frame();
        test_load_pending();
        test_lz();
        test_error_glyphs();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
